// File: rtl/uart_pkg.sv
// Shared UART definitions: width defaults, Rx configuration field offsets
// and the receive-controller state encoding.
package uart_pkg;

  localparam int unsigned MAX_UART_DATA_W_DEF = 8;
  localparam int unsigned TOTAL_CONF_W_DEF    = 5;

  // Rx configuration word layout: {data[1:0], stop[1:0], parity_en}
  localparam int unsigned PARITY_EN_BIT = 0;
  localparam int unsigned STOP_LSB      = 1;
  localparam int unsigned DATA_LSB      = 3;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_DRAIN    = 2'b10,
    ST_APPLY    = 2'b11
  } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO with async reset; the head entry is always
// visible on rdata_o while the FIFO is not empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   level_o
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_cnt_q;
  logic [PTR_W:0]   rd_cnt_q;
  logic [PTR_W:0]   level;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    level   = wr_cnt_q - rd_cnt_q;
    full_o  = (level == DEPTH_CNT);
    empty_o = (wr_cnt_q == rd_cnt_q);
    level_o = level;
    do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    do_push = push_i & (~full_o | do_pop);
    rdata_o = mem[rd_cnt_q[PTR_W-1:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_cnt_q[PTR_W-1:0]] <= wdata_i;
        wr_cnt_q                 <= wr_cnt_q + 1'b1;
      end
      if (do_pop) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: Rx enable/config sequencing, done-edge capture
// into a FWFT FIFO and sticky overrun. Optional macro UART_RX_CTRL_ERR_DROP_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned MAX_UART_DATA_W = MAX_UART_DATA_W_DEF,
  parameter int unsigned TOTAL_CONF_W    = TOTAL_CONF_W_DEF,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FIFO_PTR_W      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       cfg_wr_i,
  input  logic [TOTAL_CONF_W-1:0]    cfg_data_i,
  output logic                       cfg_ack_o,
  output logic                       rx_en_o,
  output logic [TOTAL_CONF_W-1:0]    rx_conf_o,
  input  logic                       rx_done_i,
  input  logic                       rx_busy_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_stop_err_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [MAX_UART_DATA_W-1:0] rd_data_o,
  output logic                       rd_parity_err_o,
  output logic                       rd_stop_err_o,
  output logic [FIFO_PTR_W:0]        fifo_level_o,
`ifdef UART_RX_CTRL_ERR_DROP_EN
  output logic                       err_drop_o,
`endif
  output logic                       overrun_o,
  input  logic                       ovr_clr_i
);

  localparam int unsigned ENTRY_W = MAX_UART_DATA_W + 2;

  rx_ctrl_state_t            state_q;
  rx_ctrl_state_t            state_d;
  logic                      pend_q;
  logic [TOTAL_CONF_W-1:0]   pend_data_q;
  logic [TOTAL_CONF_W-1:0]   conf_q;
  logic                      ack_q;
  logic                      done_q;
  logic                      ovr_q;
  logic                      cfg_req;

  logic                      done_rise;
  logic                      push_req;
  logic                      pop;
  logic                      ovr_event;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [ENTRY_W-1:0]        push_entry;
  logic [ENTRY_W-1:0]        head_entry;

  // A write arriving this cycle already counts as pending so DRAIN follows next cycle.
  always_comb begin
    state_d = state_q;
    cfg_req = pend_q | cfg_wr_i;
    case (state_q)
      ST_DISABLED: begin
        if (cfg_req) begin
          state_d = ST_DRAIN;
        end else if (enable_i) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (cfg_req) begin
          state_d = ST_DRAIN;
        end else if (!enable_i) begin
          state_d = ST_DISABLED;
        end
      end
      ST_DRAIN: begin
        if (!rx_busy_i) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_d = enable_i ? ST_RUNNING : ST_DISABLED;
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_comb begin
    done_rise  = rx_done_i & ~done_q;
    push_entry = {rx_stop_err_i, rx_parity_err_i, rx_data_i};
`ifdef UART_RX_CTRL_ERR_DROP_EN
    push_req   = done_rise & ~(rx_parity_err_i | rx_stop_err_i);
`else
    push_req   = done_rise;
`endif
    pop        = ~fifo_empty & rd_ready_i;
    ovr_event  = push_req & fifo_full & ~pop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_DISABLED;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      conf_q      <= '0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= rx_done_i;
      ack_q   <= (state_q == ST_APPLY);
      if (state_q == ST_APPLY) begin
        conf_q <= pend_data_q;
      end
      // A write in the APPLY cycle survives as a fresh pending request.
      if (cfg_wr_i) begin
        pend_q      <= 1'b1;
        pend_data_q <= cfg_data_i;
      end else if (state_q == ST_APPLY) begin
        pend_q <= 1'b0;
      end
      if (ovr_event) begin
        ovr_q <= 1'b1;
      end else if (ovr_clr_i) begin
        ovr_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_CTRL_ERR_DROP_EN
  logic err_drop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_drop_q <= 1'b0;
    end else begin
      err_drop_q <= done_rise & (rx_parity_err_i | rx_stop_err_i);
    end
  end

  assign err_drop_o = err_drop_q;
`endif

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (FIFO_PTR_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_req),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign rx_en_o         = (state_q == ST_RUNNING);
  assign rx_conf_o       = conf_q;
  assign cfg_ack_o       = ack_q;
  assign overrun_o       = ovr_q;
  assign rd_valid_o      = ~fifo_empty;
  assign rd_data_o       = head_entry[MAX_UART_DATA_W-1:0];
  assign rd_parity_err_o = head_entry[MAX_UART_DATA_W];
  assign rd_stop_err_o   = head_entry[MAX_UART_DATA_W+1];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: config sequencing, done-edge capture,
// FIFO boundaries and overrun, using a scoreboard queue of expected entries.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic       cfg_wr_i;
  logic [4:0] cfg_data_i;
  logic       cfg_ack_o;
  logic       rx_en_o;
  logic [4:0] rx_conf_o;
  logic       rx_done_i;
  logic       rx_busy_i;
  logic       rx_parity_err_i;
  logic       rx_stop_err_i;
  logic [7:0] rx_data_i;
  logic       rd_valid_o;
  logic       rd_ready_i;
  logic [7:0] rd_data_o;
  logic       rd_parity_err_o;
  logic       rd_stop_err_o;
  logic [2:0] fifo_level_o;
  logic       overrun_o;
  logic       ovr_clr_i;
`ifdef UART_RX_CTRL_ERR_DROP_EN
  logic       err_drop_o;
`endif

  always #5 clk_i = ~clk_i;

  uart_rx_ctrl #(
    .MAX_UART_DATA_W (8),
    .TOTAL_CONF_W    (5),
    .FIFO_DEPTH      (4),
    .FIFO_PTR_W      (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .cfg_wr_i        (cfg_wr_i),
    .cfg_data_i      (cfg_data_i),
    .cfg_ack_o       (cfg_ack_o),
    .rx_en_o         (rx_en_o),
    .rx_conf_o       (rx_conf_o),
    .rx_done_i       (rx_done_i),
    .rx_busy_i       (rx_busy_i),
    .rx_parity_err_i (rx_parity_err_i),
    .rx_stop_err_i   (rx_stop_err_i),
    .rx_data_i       (rx_data_i),
    .rd_valid_o      (rd_valid_o),
    .rd_ready_i      (rd_ready_i),
    .rd_data_o       (rd_data_o),
    .rd_parity_err_o (rd_parity_err_o),
    .rd_stop_err_o   (rd_stop_err_o),
    .fifo_level_o    (fifo_level_o),
`ifdef UART_RX_CTRL_ERR_DROP_EN
    .err_drop_o      (err_drop_o),
`endif
    .overrun_o       (overrun_o),
    .ovr_clr_i       (ovr_clr_i)
  );

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        se;
    logic        en;
    int unsigned hold;
  } vec_t;

  localparam int unsigned NVEC = 6;

  vec_t        vecs [NVEC];
  logic [9:0]  sb [$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        exp_ovr = 1'b0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit will_store(input logic pe, input logic se);
`ifdef UART_RX_CTRL_ERR_DROP_EN
    return !(pe | se);
`else
    return 1'b1;
`endif
  endfunction

  // Drives one frame: done held for 'hold' cycles then one low cycle.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic se,
                            input int unsigned hold, input logic clr);
    bit st;
    st              = will_store(pe, se);
    rx_data_i       = d;
    rx_parity_err_i = pe;
    rx_stop_err_i   = se;
    rx_done_i       = 1'b1;
    ovr_clr_i       = clr;
    if (st && sb.size() >= 4) begin
      exp_ovr = 1'b1;
    end else begin
      if (st) sb.push_back({se, pe, d});
      if (clr) exp_ovr = 1'b0;
    end
    tick();
    ovr_clr_i = 1'b0;
`ifdef UART_RX_CTRL_ERR_DROP_EN
    chk("err_drop_pulse", 32'(err_drop_o), 32'(pe | se));
`endif
    for (int unsigned i = 1; i < hold; i++) tick();
    rx_done_i = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string nm);
    int unsigned w;
    logic [9:0]  exp;
    w = 0;
    while (!rd_valid_o && w < 50) begin
      tick();
      w++;
    end
    chk({nm, "_valid"}, 32'(rd_valid_o), 32'(1));
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: no expected entry queued", nm);
      return;
    end
    exp = sb.pop_front();
    if (rd_valid_o) begin
      chk({nm, "_entry"}, 32'({rd_stop_err_o, rd_parity_err_o, rd_data_o}), 32'(exp));
      rd_ready_i = 1'b1;
      tick();
      rd_ready_i = 1'b0;
    end
  endtask

  initial begin
    logic [4:0]  cfg_a;
    int unsigned acks;
    logic        en_seen;

    vecs[0] = '{data: 8'h5A, pe: 1'b0, se: 1'b0, en: 1'b1, hold: 3};
    vecs[1] = '{data: 8'hC3, pe: 1'b1, se: 1'b0, en: 1'b1, hold: 5};
    vecs[2] = '{data: 8'h00, pe: 1'b0, se: 1'b1, en: 1'b1, hold: 2};
    vecs[3] = '{data: 8'hFF, pe: 1'b0, se: 1'b0, en: 1'b0, hold: 4};
    vecs[4] = '{data: 8'h81, pe: 1'b1, se: 1'b1, en: 1'b0, hold: 1};
    vecs[5] = '{data: 8'h7E, pe: 1'b0, se: 1'b0, en: 1'b1, hold: 8};

    rst_i = 1'b1; enable_i = 1'b0; cfg_wr_i = 1'b0; cfg_data_i = '0;
    rx_done_i = 1'b0; rx_busy_i = 1'b0; rx_parity_err_i = 1'b0; rx_stop_err_i = 1'b0;
    rx_data_i = '0; rd_ready_i = 1'b0; ovr_clr_i = 1'b0;
    repeat (3) tick();
    chk("rst_rx_en", 32'(rx_en_o), 0);
    chk("rst_ack", 32'(cfg_ack_o), 0);
    chk("rst_conf", 32'(rx_conf_o), 0);
    chk("rst_valid", 32'(rd_valid_o), 0);
    chk("rst_level", 32'(fifo_level_o), 0);
    chk("rst_ovr", 32'(overrun_o), 0);
    rst_i = 1'b0;
    tick();

    // Config from DISABLED with enable raised: ack and new conf at N+3
    cfg_a = '0;
    cfg_a[DATA_LSB +: 2] = 2'b11;
    cfg_a[STOP_LSB +: 2] = 2'b01;
    cfg_a[PARITY_EN_BIT] = 1'b1;
    enable_i = 1'b1; cfg_wr_i = 1'b1; cfg_data_i = cfg_a;
    chk("cfg_n_en", 32'(rx_en_o), 0);
    tick(); cfg_wr_i = 1'b0;
    chk("cfg_n1_en", 32'(rx_en_o), 0);
    chk("cfg_n1_ack", 32'(cfg_ack_o), 0);
    tick();
    chk("cfg_n2_en", 32'(rx_en_o), 0);
    chk("cfg_n2_ack", 32'(cfg_ack_o), 0);
    tick();
    chk("cfg_n3_ack", 32'(cfg_ack_o), 1);
    chk("cfg_n3_conf", 32'(rx_conf_o), 32'(5'b11011));
    chk("cfg_n3_en", 32'(rx_en_o), 1);
    tick();
    chk("cfg_n4_ack", 32'(cfg_ack_o), 0);

    // Config while busy, overwritten once mid-drain
    rx_busy_i = 1'b1; cfg_wr_i = 1'b1; cfg_data_i = 5'b00110;
    tick(); cfg_wr_i = 1'b0;
    acks = 0; en_seen = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      acks += 32'(cfg_ack_o);
      en_seen |= rx_en_o;
      if (i == 10) begin
        cfg_wr_i = 1'b1; cfg_data_i = 5'b01010;
      end
      tick();
      cfg_wr_i = 1'b0;
    end
    chk("busy_acks", acks, 0);
    chk("busy_en", 32'(en_seen), 0);
    rx_busy_i = 1'b0;
    chk("busy_m_ack", 32'(cfg_ack_o), 0);
    tick();
    chk("busy_m1_ack", 32'(cfg_ack_o), 0);
    tick();
    chk("busy_m2_ack", 32'(cfg_ack_o), 1);
    chk("busy_m2_conf", 32'(rx_conf_o), 32'(5'b01010));
    acks = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      acks += 32'(cfg_ack_o);
    end
    chk("busy_single_ack", acks, 0);
    chk("busy_after_en", 32'(rx_en_o), 1);

    // Long done pulse produces exactly one entry
    rx_data_i = 8'hA5; rx_parity_err_i = 1'b0; rx_stop_err_i = 1'b0; rx_done_i = 1'b1;
    sb.push_back({2'b00, 8'hA5});
    chk("a5_n_valid", 32'(rd_valid_o), 0);
    tick();
    chk("a5_n1_valid", 32'(rd_valid_o), 1);
    chk("a5_n1_level", 32'(fifo_level_o), 1);
    chk("a5_n1_data", 32'(rd_data_o), 32'(8'hA5));
    repeat (15) tick();
    rx_done_i = 1'b0;
    tick();
    chk("a5_level_once", 32'(fifo_level_o), 1);
    pop_check("a5");
    chk("a5_level_after", 32'(fifo_level_o), 0);

    // Vector table: frames with mixed flags and enable levels
    for (int unsigned v = 0; v < NVEC; v++) begin
      enable_i = vecs[v].en;
      send_frame(vecs[v].data, vecs[v].pe, vecs[v].se, vecs[v].hold, 1'b0);
      chk($sformatf("vec%0d_rx_en", v), 32'(rx_en_o), 32'(vecs[v].en));
      chk($sformatf("vec%0d_level", v), 32'(fifo_level_o), sb.size());
      if (sb.size() != 0) pop_check($sformatf("vec%0d", v));
    end
    enable_i = 1'b1;

    // Empty FIFO ignores rd_ready
    rd_ready_i = 1'b1;
    repeat (2) tick();
    rd_ready_i = 1'b0;
    chk("empty_valid", 32'(rd_valid_o), 0);
    chk("empty_level", 32'(fifo_level_o), 0);

    // Overrun: fifth frame dropped, simultaneous clear loses to the event
    for (int unsigned d = 1; d <= 4; d++) send_frame(8'(d), 1'b0, 1'b0, 2, 1'b0);
    chk("full_level", 32'(fifo_level_o), 4);
    chk("full_ovr", 32'(overrun_o), 0);
    send_frame(8'h05, 1'b0, 1'b0, 2, 1'b1);
    chk("ovr_set", 32'(overrun_o), 32'(exp_ovr));
    chk("ovr_level", 32'(fifo_level_o), 4);
    for (int unsigned d = 1; d <= 4; d++) pop_check($sformatf("ovr_rd%0d", d));
    chk("ovr_sticky", 32'(overrun_o), 1);
    ovr_clr_i = 1'b1;
    tick();
    ovr_clr_i = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_cleared", 32'(overrun_o), 0);

    // Full FIFO with push and pop in the same cycle
    for (int unsigned d = 8'h11; d <= 8'h14; d++) send_frame(8'(d), 1'b0, 1'b0, 2, 1'b0);
    rx_data_i = 8'h15; rx_parity_err_i = 1'b0; rx_stop_err_i = 1'b0;
    rx_done_i = 1'b1; rd_ready_i = 1'b1;
    chk("fp_head", 32'({rd_stop_err_o, rd_parity_err_o, rd_data_o}), 32'(sb[0]));
    tick();
    rd_ready_i = 1'b0;
    void'(sb.pop_front());
    sb.push_back({2'b00, 8'h15});
    tick();
    rx_done_i = 1'b0;
    tick();
    chk("fp_level", 32'(fifo_level_o), 4);
    chk("fp_ovr", 32'(overrun_o), 0);
    for (int unsigned d = 0; d < 4; d++) pop_check($sformatf("fp_rd%0d", d));

    // Parity error frame: dropped or stored with its flag
    send_frame(8'h3C, 1'b1, 1'b0, 4, 1'b0);
`ifdef UART_RX_CTRL_ERR_DROP_EN
    chk("perr_dropped_level", 32'(fifo_level_o), 0);
`else
    chk("perr_level", 32'(fifo_level_o), 1);
    chk("perr_flag", 32'(rd_parity_err_o), 1);
    pop_check("perr");
`endif

    // Reset mid-operation clears FIFO, pending config and rx_conf
    send_frame(8'h77, 1'b0, 1'b0, 2, 1'b0);
    rx_busy_i = 1'b1; cfg_wr_i = 1'b1; cfg_data_i = 5'b10101;
    tick();
    cfg_wr_i = 1'b0;
    rst_i = 1'b1;
    tick();
    sb.delete();
    chk("mrst_level", 32'(fifo_level_o), 0);
    chk("mrst_valid", 32'(rd_valid_o), 0);
    chk("mrst_conf", 32'(rx_conf_o), 0);
    chk("mrst_en", 32'(rx_en_o), 0);
    rst_i = 1'b0; rx_busy_i = 1'b0;
    acks = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      acks += 32'(cfg_ack_o);
    end
    chk("mrst_no_ack", acks, 0);
    chk("mrst_en_after", 32'(rx_en_o), 1);
    chk("mrst_conf_after", 32'(rx_conf_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences and configures the UART receive path. It gates the Rx enable and applies configuration changes only when the receiver is not busy. It captures each completed character, with its parity and stop error flags, into a small FIFO. It presents that FIFO to the host side through a valid/ready read port with sticky overrun reporting. It sits between the register/host logic and the Rx module, in the same clock domain.

## Interface
- MAX_UART_DATA_W, 8, width of received data
- TOTAL_CONF_W, 5, Rx configuration width {data[1:0], stop[1:0], parity_en}
- FIFO_DEPTH, 4, number of FIFO entries (power of two, ≥2)
- FIFO_PTR_W, 2, log2(FIFO_DEPTH)

Ports:
- clk_i  in  1  top clock
- rst_i  in  1  reset; asynchronous, active-high
- enable_i  in  1  host receive enable (level)
- cfg_wr_i  in  1  single-cycle request to load cfg_data_i
- cfg_data_i  in  TOTAL_CONF_W  requested configuration
- cfg_ack_o  out  1  one-cycle pulse when configuration has been applied
- rx_en_o  out  1  enable to Rx module
- rx_conf_o  out  TOTAL_CONF_W  configuration to Rx module
- rx_done_i, rx_busy_i, rx_parity_err_i, rx_stop_err_i  in  1  Rx module status
- rx_data_i  in  MAX_UART_DATA_W  Rx module data
- rd_valid_o  out  1  FIFO head valid
- rd_ready_i  in  1  host accepts head
- rd_data_o  out  MAX_UART_DATA_W  head data
- rd_parity_err_o, rd_stop_err_o  out  1  head error flags
- fifo_level_o  out  FIFO_PTR_W+1  entries held
- overrun_o  out  1  sticky overrun flag
- ovr_clr_i  in  1  clears overrun_o

## Operation
- Reset values: all outputs 0; FSM in DISABLED; pending-config flag clear.
- The FSM has four states, and rx_en_o is 1 only in RUNNING.
- DISABLED: a pending configuration goes to DRAIN; otherwise enable_i=1 goes to RUNNING.
- RUNNING: a pending configuration goes to DRAIN; otherwise enable_i=0 goes to DISABLED.
- DRAIN: waits for rx_busy_i=0, then goes to APPLY.
- APPLY (1 cycle): rx_conf_o ← pending value; cfg_ack_o=1; pending is cleared; the next state is RUNNING if enable_i=1, else DISABLED.
- cfg_wr_i in any state stores cfg_data_i in the pending register and sets the pending flag.
  - A second write before APPLY overwrites the first; only one ack is issued.
  - A write in the same cycle as APPLY is retained as a new pending value.
- rx_done_i is held high for a whole baud period, so the controller captures on its rising edge (registered previous value).
  - The capture happens in all states.
  - A frame finishing after disable is still stored.
- Push: entry {stop_err, parity_err, data} sampled from the rx_*_i inputs in the edge cycle.
- Pop: rd_valid_o && rd_ready_i.
- FIFO is first-word-fall-through; rd_* outputs are driven from storage at the read pointer.
- Full boundary:
  - Push while full with no pop in the same cycle: the new entry is dropped and overrun_o is set.
  - Push and pop in the same cycle when full: both succeed and the level is unchanged.
- Empty boundary: rd_valid_o=0 and rd_ready_i is ignored. The rd_* data outputs are don't-care.
- overrun_o clear: ovr_clr_i clears it, but a simultaneous overrun event wins (flag stays 1).
- Pointers wrap modulo FIFO_DEPTH. Level is computed as wr_cnt−rd_cnt in FIFO_PTR_W+1 bits.
- Reset mid-operation: FIFO is emptied, pending configuration is lost, and rx_conf_o returns to 0.

## Timing
- Rising edge of rx_done_i seen in cycle N: the entry is written at the end of N. rd_valid_o=1 and fifo_level_o is incremented from cycle N+1.
- Pop in cycle N: the next head or rd_valid_o=0 appears in N+1.
- cfg_wr_i in cycle N with rx_busy_i=0 and the FSM in RUNNING:
  - DRAIN in N+1, APPLY in N+2.
  - cfg_ack_o and the new rx_conf_o are visible in N+3.
  - rx_en_o is low in N+1..N+2.
- The Rx module latches the configuration on its next Idle entry. A frame started during DRAIN completes with the old configuration before APPLY.

## Configuration
- UART_RX_CTRL_ERR_DROP_EN defined: frames with rx_parity_err_i or rx_stop_err_i set at the done edge are not pushed. A one-cycle err_drop_o output pulse is emitted (port exists only under the macro).
- Undefined: every frame is pushed with its flags, and there is no err_drop_o port.

## Structure
- Shared package uart_pkg holds:
  - MAX_UART_DATA_W and TOTAL_CONF_W defaults
  - conf field offsets (PARITY_EN_BIT=0, STOP_LSB=1, DATA_LSB=3)
  - controller state encodings (DISABLED=2'b00, RUNNING=2'b01, DRAIN=2'b10, APPLY=2'b11)
- One sub-module, uart_rx_fifo: synchronous FWFT FIFO with async reset, width MAX_UART_DATA_W+2, push/pop/full/empty/level.
- The FSM, edge detector and overrun logic stay in the top module.

## Test plan
- Reset: apply enable_i=1 and cfg_wr_i with cfg_data_i=5'b11011 while rx_busy_i=0 -> cfg_ack_o pulses at N+3, rx_conf_o=5'b11011, then rx_en_o=1.
- Config while busy: cfg_wr_i with rx_busy_i=1 for 40 cycles -> stays in DRAIN with rx_en_o=0, no ack; ack 2 cycles after rx_busy_i falls.
- Done pulse held for 16 cycles with data 8'hA5 -> exactly one entry; rd_data_o=8'hA5, fifo_level_o=1, rd_valid_o=1 one cycle after the edge.
- Five frames 8'h01..8'h05 with rd_ready_i=0 -> level 4, overrun_o=1; reads return 01..04; ovr_clr_i clears the flag.
- Full FIFO, done edge and pop in the same cycle -> no overrun, level stays 4, new entry returned last.
- Frame with rx_parity_err_i=1 -> with UART_RX_CTRL_ERR_DROP_EN, not stored and err_drop_o pulses; without it, stored with rd_parity_err_o=1.
